// File: rtl/mastermind_pkg.sv
// mastermind_pkg: shared sizes, color codes and scorer state encoding
package mastermind_pkg;
  localparam int NPOS  = 4;
  localparam int CW    = 3;
  localparam int NHIST = 6;
  localparam int IW    = 3;
  localparam int CNTW  = 3;
  typedef enum logic [CW-1:0] {
    COL_0, COL_1, COL_2, COL_3, COL_4, COL_5, COL_6, COL_7
  } color_e;
  typedef enum logic [2:0] {
    S_IDLE, S_EXACT, S_PARTIAL, S_WRITE, S_DONE
  } state_e;
endpackage

// File: rtl/mastermind_hist_ram.sv
// mastermind_hist_ram: per-game guess history, sync write, valid-gated comb read
module mastermind_hist_ram #(
  parameter int NHIST = 6,
  parameter int EW    = 18,
  parameter int AW    = 3
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [EW-1:0]    wdata,
  input  logic [AW-1:0]    raddr,
  output logic [EW-1:0]    rdata,
  output logic [NHIST-1:0] valid
);
  localparam logic [AW-1:0] LIM = AW'(NHIST);
  logic [EW-1:0]    mem_q [NHIST];
  logic [EW-1:0]    mem_d [NHIST];
  logic [NHIST-1:0] valid_q, valid_d;
  logic             wr;
  // next contents: clear wins, out-of-range slots are never written
  always_comb begin
    wr = we && !clr && (waddr < LIM);
    mem_d = mem_q;
    valid_d = clr ? '0 : valid_q;
    if (wr) begin
      mem_d[waddr] = wdata;
      valid_d[waddr] = 1'b1;
    end
  end
  // data array carries no reset; reads are gated by the valid flags
  always_ff @(posedge Clk) mem_q <= mem_d;
  // valid flags
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) valid_q <= '0;
    else valid_q <= valid_d;
  assign valid = valid_q;
  assign rdata = (raddr < LIM && valid_q[raddr]) ? mem_q[raddr] : '0;
endmodule

// File: rtl/mastermind_scorer.sv
// mastermind_scorer: sequential Mastermind scoring FSM with guess history
module mastermind_scorer #(
  parameter int NPOS  = mastermind_pkg::NPOS,
  parameter int CW    = mastermind_pkg::CW,
  parameter int NHIST = mastermind_pkg::NHIST
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    start,
  input  logic                    clear,
  input  logic [NPOS*CW-1:0]      guess,
  input  logic [NPOS*CW-1:0]      target,
  input  logic [2:0]              guess_idx,
  input  logic [2:0]              rd_idx,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              exact,
  output logic [2:0]              partial,
  output logic                    win,
  output logic [NHIST-1:0]        hist_valid,
  output logic [NPOS*CW-1:0]      rd_guess,
  output logic [2:0]              rd_exact,
  output logic [2:0]              rd_partial
);
  import mastermind_pkg::*;
  localparam int PW = (NPOS > 1) ? $clog2(NPOS) : 1;
  localparam int GW = NPOS * CW;
  localparam int EW = GW + 2 * CNTW;
  localparam logic [PW-1:0]   LAST = PW'(NPOS - 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(NPOS);
  state_e            state_q, state_d;
  logic [GW-1:0]     g_q, g_d, t_q, t_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     i_q, i_d, j_q, j_d;
  logic [CNTW-1:0]   exact_q, exact_d, partial_q, partial_d;
  logic [NPOS-1:0]   gu_q, gu_d, tu_q, tu_d;
  logic              we;
  logic [EW-1:0]     rdata;
  // next state: exact pass over positions, then partial pass over all (i,j) pairs
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    t_d = t_q;
    idx_d = idx_q;
    i_d = i_q;
    j_d = j_q;
    exact_d = exact_q;
    partial_d = partial_q;
    gu_d = gu_q;
    tu_d = tu_q;
    we = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        g_d = guess;
        t_d = target;
        idx_d = guess_idx;
        i_d = '0;
        j_d = '0;
        exact_d = '0;
        partial_d = '0;
        gu_d = '0;
        tu_d = '0;
        state_d = S_EXACT;
      end
      S_EXACT: begin
        if (g_q[i_q*CW +: CW] == t_q[i_q*CW +: CW]) begin
          exact_d = exact_q + 1'b1;
          gu_d[i_q] = 1'b1;
          tu_d[i_q] = 1'b1;
        end
        i_d = (i_q == LAST) ? '0 : i_q + 1'b1;
        state_d = (i_q == LAST) ? S_PARTIAL : S_EXACT;
      end
      S_PARTIAL: begin
        if (!gu_q[i_q] && !tu_q[j_q] && g_q[i_q*CW +: CW] == t_q[j_q*CW +: CW]) begin
          partial_d = partial_q + 1'b1;
          gu_d[i_q] = 1'b1;
          tu_d[j_q] = 1'b1;
        end
        j_d = (j_q == LAST) ? '0 : j_q + 1'b1;
        i_d = (j_q == LAST) ? ((i_q == LAST) ? '0 : i_q + 1'b1) : i_q;
        state_d = (j_q == LAST && i_q == LAST) ? S_WRITE : S_PARTIAL;
      end
      S_WRITE: begin
        we = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      exact_d = '0;
      partial_d = '0;
      gu_d = '0;
      tu_d = '0;
      we = 1'b0;
    end
  end
  // state and datapath registers
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= S_IDLE;
      g_q <= '0;
      t_q <= '0;
      idx_q <= '0;
      i_q <= '0;
      j_q <= '0;
      exact_q <= '0;
      partial_q <= '0;
      gu_q <= '0;
      tu_q <= '0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      t_q <= t_d;
      idx_q <= idx_d;
      i_q <= i_d;
      j_q <= j_d;
      exact_q <= exact_d;
      partial_q <= partial_d;
      gu_q <= gu_d;
      tu_q <= tu_d;
    end
  mastermind_hist_ram #(.NHIST(NHIST), .EW(EW), .AW(IW)) u_hist (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .clr(clear),
    .we(we),
    .waddr(idx_q),
    .wdata({g_q, exact_q, partial_q}),
    .raddr(rd_idx),
    .rdata(rdata),
    .valid(hist_valid)
  );
  assign busy = state_q inside {S_EXACT, S_PARTIAL, S_WRITE};
  assign done = state_q == S_DONE;
  assign exact = exact_q;
  assign partial = partial_q;
  assign win = exact_q == FULL;
  assign rd_guess = rdata[EW-1 -: GW];
  assign rd_exact = rdata[2*CNTW-1 -: CNTW];
  assign rd_partial = rdata[CNTW-1:0];
endmodule

// File: tb/tb_mastermind_scorer.sv
// tb_mastermind_scorer: directed and random scoring checked against a color-count model
module tb_mastermind_scorer;
  logic        Clk = 0, Reset_n = 0, start = 0, clear = 0;
  logic [11:0] guess = 0, target = 0;
  logic [2:0]  guess_idx = 0, rd_idx = 0;
  logic        busy, done, win;
  logic [2:0]  exact, partial, rd_exact, rd_partial;
  logic [5:0]  hist_valid;
  logic [11:0] rd_guess;
  int total = 0, bad = 0;
  bit          hv [8];
  logic [11:0] hg [8];
  int          he [8], hp [8];
  int          e, p, n, at;

  mastermind_scorer dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .clear(clear),
    .guess(guess), .target(target), .guess_idx(guess_idx), .rd_idx(rd_idx),
    .busy(busy), .done(done), .exact(exact), .partial(partial), .win(win),
    .hist_valid(hist_valid), .rd_guess(rd_guess), .rd_exact(rd_exact),
    .rd_partial(rd_partial)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // exact = same color same place; total color overlap = sum of per-color minimum counts
  function automatic void model(input logic [11:0] g, input logic [11:0] t, output int ex, output int pa);
    int cg [8];
    int ct [8];
    int m;
    ex = 0;
    m = 0;
    for (int c = 0; c < 8; c++) begin cg[c] = 0; ct[c] = 0; end
    for (int k = 0; k < 4; k++) begin
      if (g[3*k +: 3] == t[3*k +: 3]) ex++;
      cg[g[3*k +: 3]]++;
      ct[t[3*k +: 3]]++;
    end
    for (int c = 0; c < 8; c++) m += (cg[c] < ct[c]) ? cg[c] : ct[c];
    pa = m - ex;
  endfunction

  function automatic logic [5:0] hvec();
    logic [5:0] v;
    for (int k = 0; k < 6; k++) v[k] = hv[k];
    return v;
  endfunction

  function automatic logic [11:0] rnd_code();
    logic [11:0] v;
    int hi;
    hi = ($urandom_range(0, 1) == 1) ? 3 : 7;
    for (int k = 0; k < 4; k++) v[3*k +: 3] = 3'($urandom_range(0, hi));
    return v;
  endfunction

  task automatic score(input logic [11:0] g, input logic [11:0] t, input logic [2:0] idx, input string tag);
    int ex, pa, k;
    model(g, t, ex, pa);
    guess = g;
    target = t;
    guess_idx = idx;
    start = 1;
    tick;
    start = 0;
    chk({tag, "_busy"}, 32'(busy), 1);
    k = 0;
    while (!done && k < 40) begin tick; k++; end
    chk({tag, "_latency"}, k, 21);
    chk({tag, "_exact"}, 32'(exact), ex);
    chk({tag, "_partial"}, 32'(partial), pa);
    chk({tag, "_win"}, 32'(win), (ex == 4) ? 1 : 0);
    if (idx < 6) begin hv[idx] = 1; hg[idx] = g; he[idx] = ex; hp[idx] = pa; end
    tick;
    chk({tag, "_done_drop"}, 32'(done), 0);
    chk({tag, "_hist_valid"}, 32'(hist_valid), 32'(hvec()));
  endtask

  task automatic check_reads(input string tag);
    logic [17:0] want;
    for (int r = 0; r < 8; r++) begin
      rd_idx = 3'(r);
      #1;
      want = (r < 6 && hv[r]) ? {hg[r], 3'(he[r]), 3'(hp[r])} : 18'd0;
      chk($sformatf("%s_rd%0d", tag, r), 32'({rd_guess, rd_exact, rd_partial}), 32'(want));
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) hv[k] = 0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_exact", 32'(exact), 0);
    chk("rst_partial", 32'(partial), 0);
    chk("rst_win", 32'(win), 0);
    chk("rst_hist_valid", 32'(hist_valid), 0);
    tick;
    Reset_n = 1;
    tick;
    score(12'o1234, 12'o1234, 0, "all_exact");
    score(12'o4321, 12'o1234, 1, "all_partial");
    score(12'o2211, 12'o1223, 2, "dup_a");
    score(12'o1111, 12'o1123, 3, "dup_b");
    score(12'o0000, 12'o0120, 4, "color0");
    check_reads("directed");
    // second start during scoring and input changes must not disturb the run
    model(12'o3312, 12'o1233, e, p);
    guess = 12'o3312;
    target = 12'o1233;
    guess_idx = 5;
    start = 1;
    tick;
    n = 0;
    at = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin start = 1; guess = 12'o7777; target = 12'o7777; guess_idx = 0; end
      else start = 0;
      tick;
      if (done) begin n++; if (at == 0) at = k; end
    end
    chk("ign_done_count", n, 1);
    chk("ign_done_at", at, 21);
    chk("ign_exact", 32'(exact), e);
    chk("ign_partial", 32'(partial), p);
    hv[5] = 1; hg[5] = 12'o3312; he[5] = e; hp[5] = p;
    score(12'o6655, 12'o5566, 5, "after_ign");
    for (int k = 0; k < 16; k++) score(rnd_code(), rnd_code(), 3'($urandom_range(0, 7)), $sformatf("rnd%0d", k));
    check_reads("random");
    // clear at cycle 10 of a run after filling every slot
    for (int k = 0; k < 6; k++) score(rnd_code(), rnd_code(), 3'(k), $sformatf("fill%0d", k));
    guess = 12'o1111;
    target = 12'o1111;
    guess_idx = 2;
    start = 1;
    tick;
    start = 0;
    for (int k = 1; k < 10; k++) tick;
    clear = 1;
    tick;
    clear = 0;
    for (int k = 0; k < 8; k++) hv[k] = 0;
    chk("clr_busy", 32'(busy), 0);
    chk("clr_exact", 32'(exact), 0);
    chk("clr_partial", 32'(partial), 0);
    chk("clr_hist_valid", 32'(hist_valid), 0);
    n = 0;
    for (int k = 0; k < 25; k++) begin tick; if (done) n++; end
    chk("clr_no_done", n, 0);
    check_reads("clr");
    // clear beats a simultaneous start
    start = 1;
    clear = 1;
    tick;
    start = 0;
    clear = 0;
    chk("clr_start_busy", 32'(busy), 0);
    n = 0;
    for (int k = 0; k < 25; k++) begin tick; if (done) n++; end
    chk("clr_start_no_done", n, 0);
    // asynchronous reset in the partial pass
    score(12'o1357, 12'o7531, 1, "pre_rst");
    guess = 12'o2222;
    target = 12'o2222;
    guess_idx = 3;
    start = 1;
    tick;
    start = 0;
    for (int k = 1; k < 9; k++) tick;
    Reset_n = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_exact", 32'(exact), 0);
    chk("arst_partial", 32'(partial), 0);
    chk("arst_win", 32'(win), 0);
    chk("arst_hist_valid", 32'(hist_valid), 0);
    for (int k = 0; k < 8; k++) hv[k] = 0;
    tick;
    tick;
    Reset_n = 1;
    n = 0;
    for (int k = 0; k < 25; k++) begin tick; if (done) n++; end
    chk("arst_no_done", n, 0);
    score(12'o0413, 12'o3104, 2, "post_rst");
    score(12'o1234, 12'o1234, 6, "idx6");
    chk("idx6_hist_valid", 32'(hist_valid), 32'(6'b000100));
    check_reads("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mastermind_scorer.md
MASTERMIND_SCORER -- requirements
Module: mastermind_scorer

Interface
REQ-001 SHALL have parameters: NPOS, default 4, number of peg positions; CW, default 3, color width in bits; NHIST, default 6, history depth.
REQ-002 SHALL have port: Clk  input  1  rising-edge system clock.
REQ-003 SHALL have port: Reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  one-cycle request to score the current guess.
REQ-005 SHALL have port: clear  input  1  new-game pulse; empties the history.
REQ-006 SHALL have port: guess  input  12  submitted guess; position p occupies bits [3p+2:3p].
REQ-007 SHALL have port: target  input  12  correct answer, same packing as guess.
REQ-008 SHALL have port: guess_idx  input  3  history slot for this guess, 0..5.
REQ-009 SHALL have port: rd_idx  input  3  history read address.
REQ-010 SHALL have port: busy  output  1  high while scoring.
REQ-011 SHALL have port: done  output  1  one-cycle pulse when results are valid.
REQ-012 SHALL have port: exact  output  3  count of right color in the right position.
REQ-013 SHALL have port: partial  output  3  count of right color in the wrong position.
REQ-014 SHALL have port: win  output  1  high when exact == 4.
REQ-015 SHALL have port: hist_valid  output  6  per-slot written flags.
REQ-016 SHALL have port: rd_guess/rd_exact/rd_partial  output  12/3/3  combinational read of slot rd_idx.

Function
REQ-017 SHALL implement FSM states IDLE, EXACT, PARTIAL, WRITE, DONE.
REQ-018 IDLE with start=1 SHALL capture guess, target and guess_idx, clear the counters and match masks, and move to EXACT.
REQ-019 EXACT SHALL compare one position per cycle, i=0..3, 4 cycles; each equal position increments exact and sets both guess_used[i] and tgt_used[i].
REQ-020 PARTIAL SHALL take one (i,j) pair per cycle, i outer and j inner, 16 cycles.
REQ-021 In PARTIAL, if !guess_used[i], !tgt_used[j] and g[i]==t[j], the block SHALL increment partial and set guess_used[i] and tgt_used[j].
REQ-022 Scoring SHALL therefore follow standard Mastermind duplicate rules; color 0 SHALL get no special treatment.
REQ-023 WRITE (1 cycle) SHALL store {guess, exact, partial} into slot guess_idx and set hist_valid[guess_idx]; if guess_idx>5, WRITE SHALL make no write.
REQ-024 DONE (1 cycle) SHALL assert done, then return to IDLE.
REQ-025 busy SHALL be high in EXACT, PARTIAL and WRITE.
REQ-026 done SHALL rise exactly 21 clock edges after the edge that samples start.
REQ-027 exact, partial and win SHALL hold their last values until the next start is accepted.
REQ-028 start while not IDLE SHALL be ignored.
REQ-029 Changes on guess/target during scoring SHALL have no effect.
REQ-030 clear in any state SHALL zero hist_valid and return the FSM to IDLE without pulsing done; exact/partial SHALL be zeroed.
REQ-031 clear and start in the same cycle: clear SHALL win and start is dropped.
REQ-032 Rewriting an already-valid slot SHALL overwrite it.
REQ-033 Reading a slot with hist_valid=0 or rd_idx>5 SHALL return all zeros.
REQ-034 Counters SHALL be 3 bits and saturate-free, since the maximum count is 4.
REQ-035 exact+partial SHALL never exceed 4.

Reset
REQ-036 Reset_n low SHALL asynchronously force: IDLE, busy=0, done=0, exact=0, partial=0, win=0, hist_valid=0, match masks cleared.
REQ-037 History data need not be reset; reads are gated by hist_valid.
REQ-038 Reset mid-scoring SHALL abort with no write and no done.

Structure
REQ-039 Shared package mastermind_pkg SHALL hold CW, NPOS, NHIST, the color encodings and the scorer state encodings.
REQ-040 History storage SHALL be sub-module mastermind_hist_ram: 6 x 18-bit, synchronous write, combinational read.
REQ-041 The FSM, the i/j indices and the counters SHALL remain in mastermind_scorer.

Verification
REQ-042 target=o1234, guess=o1234 -> exact=4, partial=0, win=1, done 21 edges after start.
REQ-043 target=o1234, guess=o4321 -> exact=0, partial=4, win=0.
REQ-044 target=o1223, guess=o2211 -> exact=1, partial=2; target=o1123, guess=o1111 -> exact=2, partial=0.
REQ-045 Second start pulsed at cycle 5 of a scoring run -> ignored, a single done; the next start after done is scored.
REQ-046 Score with guess_idx=0..5, then clear mid-run at cycle 10 -> hist_valid=0, no done, reads return zeros.
REQ-047 Reset_n low during PARTIAL -> all outputs zero at once; guess_idx=6 scored afterward -> results valid, hist_valid unchanged.
